// File: rtl/mips_main_controller.sv
// Multicycle MIPS main control FSM.
// Steps fetch/decode/execute/memory/writeback and drives datapath controls.
module mips_main_controller #(
    parameter int OP_WIDTH    = 6,
    parameter int STATE_WIDTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [OP_WIDTH-1:0]    Op,
    input  logic                   Zero,
    output logic                   IorD,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             ALUOp,
    output logic [1:0]             PCSrc,
    output logic                   s_notz,
    output logic                   PCEn,
    output logic [STATE_WIDTH-1:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
    localparam logic [OP_WIDTH-1:0] OP_RTYP = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_ANDI = OP_WIDTH'(6'b001100);
    localparam logic [OP_WIDTH-1:0] OP_ORI  = OP_WIDTH'(6'b001101);
    localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);

    state_t state;
    state_t next;
    logic   run;

    logic is_mem;
    logic is_sw;
    logic is_rtyp;
    logic is_beq;
    logic is_imm;
    logic is_logic;
    logic is_j;

    logic ir_write;
    logic pc_write;
    logic reg_write;
    logic mem_write;
    logic branch;

    assign is_sw    = (Op == OP_SW);
    assign is_mem   = (Op == OP_LW) || is_sw;
    assign is_rtyp  = (Op == OP_RTYP);
    assign is_beq   = (Op == OP_BEQ);
    assign is_logic = (Op == OP_ANDI) || (Op == OP_ORI);
    assign is_imm   = (Op == OP_ADDI) || is_logic;
    assign is_j     = (Op == OP_J);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= FETCH;
            run   <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= run ? next : FETCH;
        end
    end

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:   next = DECODE;
            DECODE: begin
                unique case (1'b1)
                    is_mem:  next = MEMADR;
                    is_rtyp: next = EXECUTE;
                    is_beq:  next = BRANCH;
                    is_imm:  next = IMMEX;
                    is_j:    next = JUMP;
                    default: next = FETCH;
                endcase
            end
            MEMADR:  next = is_sw ? MEMWR : MEMRD;
            MEMRD:   next = MEMWB;
            EXECUTE: next = ALUWB;
            IMMEX:   next = IMMWB;
            default: next = FETCH;
        endcase
    end

    always_comb begin
        IorD      = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        PCSrc     = 2'b00;
        s_notz    = 1'b1;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB  = 2'b01;
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD:   IorD = 1'b1;
            MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
            end
            MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = is_logic ? 2'b11 : 2'b00;
                s_notz  = ~is_logic;
            end
            IMMWB: begin
                reg_write = 1'b1;
                s_notz    = ~is_logic;
            end
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by run so reset drops them without a clock.
    assign IRWrite  = ir_write & run;
    assign RegWrite = reg_write & run;
    assign MemWrite = mem_write & run;
    assign PCEn     = (pc_write | (branch & Zero)) & run;
    assign State    = STATE_WIDTH'(state);

endmodule

// File: tb/tb_mips_main_controller.sv
// Bench for mips_main_controller: per-instruction state walks
// checked against an opcode-level sequence model.
module tb_mips_main_controller;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] Op = 6'd0;
    logic       Zero = 1'b0;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, s_notz, PCEn;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, J = 6'b000010;

    // bit order of the packed output vector
    localparam logic [14:0] STROBES = 15'b011_001_0_00_00_00_0_1;
    localparam logic [14:0] ALUOP_M = 15'b000_000_0_00_11_00_0_0;

    mips_main_controller dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .s_notz(s_notz), .PCEn(PCEn), .State(State)
    );

    always #5 CLK = ~CLK;

    function automatic logic [14:0] outs();
        return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc, s_notz, PCEn};
    endfunction

    // Instruction-level model: the list of states an opcode visits.
    function automatic void path(input logic [5:0] op, output int q[$]);
        q = {0, 1};
        case (op)
            LW:               q = {0, 1, 2, 3, 4};
            SW:               q = {0, 1, 2, 5};
            RT:               q = {0, 1, 6, 7};
            BEQ:              q = {0, 1, 8};
            ADDI, ANDI, ORI:  q = {0, 1, 9, 10};
            J:                q = {0, 1, 11};
            default:          q = {0, 1};
        endcase
    endfunction

    // Output table per state, with run already set.
    function automatic logic [14:0] expect_out(input int st,
            input logic [5:0] op, input logic z);
        logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0;
        logic [1:0] asb = 0, aop = 0, pcs = 0;
        logic lg = (op == ANDI) || (op == ORI);
        logic sn = 1, pcw = 0, br = 0;
        case (st)
            0:  begin asb = 1; irw = 1; pcw = 1; end
            1:  asb = 3;
            2:  begin asa = 1; asb = 2; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin asa = 1; aop = 2; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 1; pcs = 1; br = 1; end
            9:  begin asa = 1; asb = 2; aop = lg ? 2'd3 : 2'd0; sn = !lg; end
            10: begin rw = 1; sn = !lg; end
            11: begin pcs = 2; pcw = 1; end
            default: ;
        endcase
        return {iord, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, sn,
                pcw | (br & z)};
    endfunction

    // Called at a negedge; leaves RST high and run set, at a negedge.
    task automatic do_reset(input int hold);
        logic [14:0] e;
        RST = 1'b0;
        e = expect_out(0, Op, 1'b0) & ~STROBES;
        for (int i = 0; i < hold; i++) begin
            #1;
            checks++;
            if (outs() !== e || State !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold%0d outs=%b state=%0d want outs=%b state=0",
                         i, outs(), State, e);
            end
            @(negedge CLK);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (outs() !== e || State !== 4'd0) begin
            errors++;
            $display("FAIL reset_release outs=%b state=%0d want outs=%b state=0",
                     outs(), State, e);
        end
        @(negedge CLK);
    endtask

    // zmode: 0/1 forces Zero, 2 randomizes it every cycle.
    task automatic run_instr(input logic [5:0] op, input int zmode,
                             input string tag);
        int q[$];
        logic [14:0] e, m;
        path(op, q);
        Op = op;
        foreach (q[k]) begin
            Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            e = expect_out(q[k], op, Zero);
            m = (q[k] == 10) ? ~ALUOP_M : '1;
            checks++;
            if (State !== 4'(q[k]) || (outs() & m) !== (e & m)) begin
                errors++;
                $display("FAIL %s op=%b step%0d state=%0d outs=%b want state=%0d outs=%b",
                         tag, op, k, State, outs() & m, q[k], e & m);
            end
            @(negedge CLK);
        end
        checks++;
        if (State !== 4'd0) begin
            errors++;
            $display("FAIL %s_return op=%b state=%0d want 0", tag, op, State);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        do_reset(3);
    endtask

    task automatic test_lw();
        run_instr(LW, 2, "lw");
    endtask

    task automatic test_branch();
        run_instr(BEQ, 1, "beq_taken");
        run_instr(BEQ, 0, "beq_not_taken");
        run_instr(J, 2, "jump");
    endtask

    task automatic test_imm();
        run_instr(ORI, 2, "ori");
        run_instr(ADDI, 2, "addi");
        run_instr(ANDI, 2, "andi");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 2, "illegal");
        run_instr(6'b000001, 2, "illegal");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8] = '{LW, SW, RT, BEQ, ADDI, ANDI, ORI, J};
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                             : ops[$urandom_range(0, 7)];
            run_instr(op, 2, "random");
        end
    endtask

    task automatic test_reset_mid();
        Op = SW;
        repeat (3) @(negedge CLK);
        checks++;
        if (State !== 4'd5 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL pre_mid_reset state=%0d memwrite=%b want 5/1",
                     State, MemWrite);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (State !== 4'd0 || MemWrite !== 1'b0 || PCEn !== 1'b0 ||
            IRWrite !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset state=%0d mw=%b pcen=%b irw=%b rw=%b want 0/0/0/0/0",
                     State, MemWrite, PCEn, IRWrite, RegWrite);
        end
        @(negedge CLK);
        do_reset(1);
        run_instr(RT, 2, "after_mid_reset");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_imm();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
